// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
//   Sequential shift-add unsigned multiplier. It retires one multiplier bit per
//   clock, so a WIDTH x WIDTH multiply takes exactly WIDTH RUN cycles. A
//   start/done handshake connects it to the issuing controller.
//
// Ports
//   clock    : rising-edge clock, the only clock
//   reset    : synchronous, active-high; aborts any operation in flight
//   start    : multiply request; sampled only in IDLE or DONE
//   a, b     : multiplicand / multiplier, captured on the accepting edge
//   busy     : high while iterating (state RUN)
//   done     : one-cycle pulse, product valid
//   product  : {A,Q}; holds until the next accepted start
// -----------------------------------------------------------------------------
module seq_mult_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   m_reg;      // multiplicand
    logic [WIDTH:0]     a_reg;      // accumulator, top bit catches the carry
    logic [WIDTH-1:0]   q_reg;      // multiplier, becomes product low half
    logic [CNTW-1:0]    cnt_reg;

    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum_next;

    // Partial product for this iteration: M gated by the multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = m_reg[gi] & q_reg[0];
        end
    endgenerate
    assign addend[WIDTH] = 1'b0;

    // A never exceeds WIDTH bits after a shift, so a WIDTH+1 bit sum is exact.
    assign sum_next = a_reg + addend;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        m_reg     <= a;
                        q_reg     <= b;
                        a_reg     <= '0;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    // {A,Q} <= {sum,Q} >> 1: sum LSB moves into Q's MSB.
                    a_reg   <= {1'b0, sum_next[WIDTH:1]};
                    q_reg   <= {sum_next[0], q_reg[WIDTH-1:1]};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Status decoded straight from the state register, so busy and done are
    // mutually exclusive by construction.
    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = {a_reg[WIDTH-1:0], q_reg};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_ctrl
//   Self-checking bench for seq_mult_ctrl: a table of directed operand pairs,
//   hand-written corner sequences (ignored start, mid-run reset, back-to-back
//   start in DONE) and 1000 random pairs against a plain a*b reference.
// -----------------------------------------------------------------------------
module tb_seq_mult_ctrl;

    localparam int WIDTH = 16;
    localparam int CNTW  = 5;

    logic                clock;
    logic                reset;
    logic                start;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                busy;
    logic                done;
    logic [2*WIDTH-1:0]  product;

    int vectors     = 0;
    int miscompares = 0;

    seq_mult_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clock) begin
        if (busy === 1'b1 && done === 1'b1) begin
            miscompares++;
            $display("FAIL busy_done_overlap: got busy=1 done=1, expected not both");
        end
    end

    // Global time bound so the run can never hang.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Called at a negedge while the DUT is in IDLE or DONE. Issues a start,
    // optionally injects a stray start at RUN iteration inject_at, and returns
    // at the negedge of the DONE cycle after checking latency and product.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic [2*WIDTH-1:0] exp, input int inject_at,
                          input string tag);
        int n;
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(negedge clock);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == inject_at) begin
                start = 1'b1;
                a     = 16'd7;
                b     = 16'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check({tag, "_run_cycles"}, 64'(n), 64'(WIDTH));
        check({tag, "_done"},       64'(done), 64'd1);
        check({tag, "_product"},    64'(product), 64'(exp));
        $display("op %s: a=0x%04h b=0x%04h product=0x%08h expected=0x%08h run_cycles=%0d",
                 tag, op_a, op_b, product, exp, n);
    endtask

    vec_t table_v[6];

    initial begin
        int gap;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [2*WIDTH-1:0] last_exp;

        table_v[0] = '{16'd3,    16'd5,    32'h0000_000F};
        table_v[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        table_v[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
        table_v[3] = '{16'h0000, 16'hABCD, 32'h0000_0000};
        table_v[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
        table_v[5] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clock);
        check("reset_busy",    64'(busy), 64'd0);
        check("reset_done",    64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed table; after each DONE, check return to IDLE with product held.
        for (int i = 0; i < 6; i++) begin
            run_op(table_v[i].a, table_v[i].b, table_v[i].exp, -1, $sformatf("table%0d", i));
            @(negedge clock);
            check($sformatf("table%0d_idle_done", i), 64'(done), 64'd0);
            check($sformatf("table%0d_idle_busy", i), 64'(busy), 64'd0);
            check($sformatf("table%0d_hold", i),      64'(product), 64'(table_v[i].exp));
        end

        // Stray start at RUN cycle 5 must be ignored.
        run_op(16'd3, 16'd5, 32'h0000_000F, 5, "ignore_start");
        @(negedge clock);
        check("ignore_start_idle", 64'(busy), 64'd0);

        // Reset at RUN cycle 8 aborts with no done pulse.
        start = 1'b1; a = 16'd3; b = 16'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("midrun_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrun_reset_busy",    64'(busy), 64'd0);
        check("midrun_reset_done",    64'(done), 64'd0);
        check("midrun_reset_product", 64'(product), 64'd0);
        begin
            int seen_done = 0;
            int seen_busy = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (done === 1'b1) seen_done++;
                if (busy === 1'b1) seen_busy++;
            end
            check("midrun_no_done", 64'(seen_done), 64'd0);
            check("midrun_no_busy", 64'(seen_busy), 64'd0);
        end

        // Reset and start together: reset wins.
        reset = 1'b1; start = 1'b1; a = 16'd2; b = 16'd2;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        check("reset_start_busy", 64'(busy), 64'd0);
        @(negedge clock);
        check("reset_start_busy2", 64'(busy), 64'd0);

        // Back-to-back: start held in DONE; prior product visible in DONE.
        run_op(16'd3, 16'd5, 32'h0000_000F, -1, "b2b_first");
        run_op(16'h8000, 16'd2, 32'h0001_0000, -1, "b2b_second");
        @(negedge clock);

        // Random operand pairs against the arithmetic reference, random gaps.
        last_exp = 32'h0001_0000;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'hFFFF;
                1: rb = 16'hFFFF;
                2: ra = 16'h0000;
                default: ;
            endcase
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                if (g == gap - 1)
                    check($sformatf("rand%0d_hold", i), 64'(product), 64'(last_exp));
            end
            last_exp = 32'(ra) * 32'(rb);
            run_op(ra, rb, last_exp, -1, $sformatf("rand%0d", i));
        end
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
